// File: rtl/register_vga_renderer.sv
// register_vga_renderer: VGA timing plus an 11-row x 4-digit hex dump of a per-frame register snapshot
// ports: clk, rst (sync, active-high); registersVGA = R0 at [175:160] .. RA at [15:0];
//        hsync/vsync active-low; vgaR/vgaG/vgaB 3-bit colour; frameStart pulses when the snapshot is taken
module register_vga_renderer #(
  parameter int H_ORIGIN = 64,
  parameter int V_ORIGIN = 48,
  parameter int H_VIS = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_VIS = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [175:0] registersVGA,
  output logic         hsync,
  output logic         vsync,
  output logic [2:0]   vgaR,
  output logic [2:0]   vgaG,
  output logic [2:0]   vgaB,
  output logic         frameStart
);
  localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_L = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L = 10'(V_VIS);
  localparam logic [9:0] HS0 = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS1 = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS0 = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS1 = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] HX0 = 10'(H_ORIGIN);
  localparam logic [9:0] HX1 = 10'(H_ORIGIN + 80);
  localparam logic [9:0] VY0 = 10'(V_ORIGIN);
  localparam logic [9:0] VY1 = 10'(V_ORIGIN + 264);
  // 4x5 glyphs, five 4-bit rows top first, bit 3 of each row is the leftmost column
  localparam logic [19:0] FONT [16] = '{
    20'hF999F, 20'h26227, 20'hF1F8F, 20'hF1F1F, 20'h99F11, 20'hF8F1F, 20'hF8F9F, 20'hF1244,
    20'hF9F9F, 20'hF9F1F, 20'hF9F99, 20'hE9E9E, 20'hF888F, 20'hE999E, 20'hF8F8F, 20'hF8E88
  };
  logic         r_phase;
  logic [9:0]   r_h;
  logic [9:0]   r_v;
  logic [175:0] r_snap;
  logic [4:0]   r_px;
  logic [1:0]   r_col;
  logic [4:0]   r_py;
  logic [3:0]   r_row;
  logic         r_hs;
  logic         r_vs;
  logic [2:0]   r_rgb;
  logic         r_fs;
  logic         w_tick;
  logic         w_latch;
  logic         w_in;
  logic         w_lit;
  logic [9:0]   w_h_next;
  logic [9:0]   w_v_next;
  logic [15:0]  w_reg;
  logic [3:0]   w_nib;
  logic [19:0]  w_glyph;
  logic [3:0]   w_bits;
  // r_px/r_col and r_py/r_row always describe the current r_h/r_v cell position;
  // they restart whenever the counters step onto the display origin
  always_comb begin
    w_tick = r_phase;
    w_latch = r_h == 10'd0 && r_v == V_VIS_L;
    w_h_next = r_h == H_LAST ? 10'd0 : r_h + 10'd1;
    w_v_next = r_v == V_LAST ? 10'd0 : r_v + 10'd1;
    w_in = r_h < H_VIS_L && r_v < V_VIS_L && r_h >= HX0 && r_h < HX1 && r_v >= VY0 && r_v < VY1
           && r_px < 5'd16 && r_py < 5'd20;
    w_reg = 16'h0;
    for (int i = 0; i < 11; i++) w_reg = r_row == 4'(i) ? r_snap[175 - 16 * i -: 16] : w_reg;
    w_nib = r_col == 2'd0 ? w_reg[15:12] : r_col == 2'd1 ? w_reg[11:8] : r_col == 2'd2 ? w_reg[7:4] : w_reg[3:0];
    w_glyph = FONT[w_nib];
    w_bits = r_py[4:2] == 3'd0 ? w_glyph[19:16] : r_py[4:2] == 3'd1 ? w_glyph[15:12] :
             r_py[4:2] == 3'd2 ? w_glyph[11:8] : r_py[4:2] == 3'd3 ? w_glyph[7:4] : w_glyph[3:0];
    w_lit = w_in && w_bits[~r_px[3:2]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= 1'b0;
      r_h <= '0;
      r_v <= '0;
      r_snap <= '0;
      r_px <= '0;
      r_col <= '0;
      r_py <= '0;
      r_row <= '0;
      r_hs <= 1'b1;
      r_vs <= 1'b1;
      r_rgb <= '0;
      r_fs <= 1'b0;
    end else begin
      r_phase <= ~r_phase;
      r_fs <= w_tick && w_latch;
      if (w_tick) begin
        r_h <= w_h_next;
        r_px <= w_h_next == HX0 || r_px == 5'd19 ? 5'd0 : r_px + 5'd1;
        r_col <= w_h_next == HX0 ? 2'd0 : r_px == 5'd19 ? r_col + 2'd1 : r_col;
        if (r_h == H_LAST) begin
          r_v <= w_v_next;
          r_py <= w_v_next == VY0 || r_py == 5'd23 ? 5'd0 : r_py + 5'd1;
          r_row <= w_v_next == VY0 ? 4'd0 : r_py == 5'd23 ? r_row + 4'd1 : r_row;
        end
        if (w_latch) r_snap <= registersVGA;
        r_hs <= !(r_h >= HS0 && r_h < HS1);
        r_vs <= !(r_v >= VS0 && r_v < VS1);
        r_rgb <= {3{w_lit}};
      end
    end
  end
  assign hsync = r_hs;
  assign vsync = r_vs;
  assign vgaR = r_rgb;
  assign vgaG = r_rgb;
  assign vgaB = r_rgb;
  assign frameStart = r_fs;
endmodule

// File: doc/register_vga_renderer.md
REGISTER_VGA_RENDERER -- requirements
Module: register_vga_renderer

Interface
REQ-001 Parameter: H_ORIGIN, 64, x pixel of left edge of register display area.
REQ-002 Parameter: V_ORIGIN, 48, y line of top edge of register display area.
REQ-003 Port: clk  in  1  system clock, 50 MHz; single clock domain.
REQ-004 Port: rst  in  1  reset; synchronous, active-high.
REQ-005 Port: registersVGA  in  176  register dump; bits [175:160]=R0, then R1..R7, IH, SP, RA at [15:0].
REQ-006 Port: hsync  out  1  horizontal sync, active-low.
REQ-007 Port: vsync  out  1  vertical sync, active-low.
REQ-008 Port: vgaR, vgaG, vgaB  out  3 each  pixel colour.
REQ-009 Port: frameStart  out  1  one-clk pulse when snapshot taken.

Function
REQ-010 Pixel tick SHALL assert every second clk; first tick on the 2nd clk edge after rst deasserts.
REQ-011 hcount 0..799 SHALL advance per tick and wrap 799->0; vcount 0..524 SHALL advance when hcount wraps and wrap 524->0.
REQ-012 Horizontal: visible 0-639, front porch 640-655, sync 656-751, back porch 752-799.
REQ-013 Vertical: visible 0-479, front porch 480-489, sync 490-491, back porch 492-524.
REQ-014 hsync/vsync/RGB SHALL be registered and mutually aligned, reflecting counter value of the previous tick (1-tick latency).
REQ-015 On the tick where hcount=0, vcount=480, the full 176-bit registersVGA SHALL be latched into a snapshot; frameStart SHALL pulse for that single clk.
REQ-016 Display SHALL use only the snapshot; input changes mid-frame SHALL NOT affect the current frame.
REQ-017 Layout: 11 rows (R0 top .. RA bottom), 4 hex digits per row, most-significant nibble leftmost.
REQ-018 Cell: 20 px wide x 24 lines tall; glyph 4x5 font scaled x4 (16x20) in the cell's top-left; remaining 4 px column / 4 lines are gap.
REQ-019 Display area spans x H_ORIGIN..H_ORIGIN+79, y V_ORIGIN..V_ORIGIN+263.
REQ-020 Cell position SHALL be tracked by counters; no dividers.
REQ-021 Font: built-in 16 glyphs, 5 rows of 4 bits, bit 3 = leftmost; '0'=F,9,9,9,F; '1'=2,6,2,2,7; '8'=F,9,F,9,F; 'F'=F,8,E,8,8; remaining digits per team font table.
REQ-022 Lit glyph pixel SHALL output 3'b111 on all channels; unlit, gap and outside-area visible pixels 3'b000.
REQ-023 Outside visible region RGB SHALL be 3'b000 regardless of position.
REQ-024 Snapshot latch and pixel generation on the same tick SHALL not conflict (latch occurs in blanking).

Reset
REQ-025 While rst high at a clk edge: tick phase=0, hcount=0, vcount=0, snapshot=0, hsync=1, vsync=1, RGB=0, frameStart=0.
REQ-026 rst asserted mid-frame SHALL restart timing at hcount=0, vcount=0 on the next edge; first frame displays all-zero snapshot until first latch.
REQ-027 No output SHALL glitch or be X after the first clk edge with rst high.

Verification
REQ-028 Reset then run 2 frames -> hsync low exactly 96 ticks per line, period 800 ticks; vsync low 2 lines per 525-line frame.
REQ-029 registersVGA R0=16'h0008 held, one frame -> row 0 digits '0','0','0','8'; pixel (H_ORIGIN+60, V_ORIGIN+0) white, (H_ORIGIN+16, V_ORIGIN) black (gap).
REQ-030 RA=16'hF000, others 0 -> row 10 first cell at y=V_ORIGIN+240 shows 'F' top row lit x H_ORIGIN..H_ORIGIN+15.
REQ-031 Change registersVGA at vcount=200 -> current frame unchanged; new value shown next frame; frameStart pulses once per frame at vcount=480.
REQ-032 Assert rst for 1 clk at vcount=300 -> next edge hcount=0, vcount=0, outputs at reset values, snapshot=0 (display all '0' until next latch).
REQ-033 Pixel at hcount=700, vcount=100 and at vcount=500 -> RGB=0.
